// File: rtl/ej32_pkg.sv
// ---------------------------------------------------------------------------
// ej32_pkg
// Shared types and defaults for the eJ32 instruction fetch slice.
//   fetch_st_t          : fetch FSM state encoding (IDLE, BUSY, FLUSH)
//   FETCH_DEPTH_DEF     : default prefetch FIFO depth in bytes
//   FETCH_RST_ADDR_DEF  : default fetch address after reset
// ---------------------------------------------------------------------------
package ej32_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FLUSH = 2'd2
   } fetch_st_t;

   localparam int unsigned FETCH_DEPTH_DEF    = 4;
   localparam int unsigned FETCH_RST_ADDR_DEF = 0;

endpackage

// File: rtl/ej32_fifo.sv
// ---------------------------------------------------------------------------
// ej32_fifo
// Byte FIFO used as the eJ32 prefetch buffer.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active-low
//   clr    in   synchronous clear (empties the FIFO, wins over push/pop)
//   push   in   write wdata (ignored when full)
//   pop    in   drop head byte (ignored when empty)
//   wdata  in   byte to write
//   head   out  byte at the read pointer (meaningful only when count != 0)
//   count  out  number of stored bytes, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ej32_fifo import ej32_pkg::*; #(
   parameter int unsigned DEPTH = FETCH_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && (count != CW'(DEPTH)) && !clr;
   assign do_pop  = pop  && (count != '0) && !clr;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (rst && do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ej32_fetch.sv
// ---------------------------------------------------------------------------
// ej32_fetch
// Instruction fetch / prefetch stage feeding the eJ32 decoder. Reads bytes
// from instruction memory one request at a time, buffers them in ej32_fifo
// and presents the head byte to the decoder. A BR redirect flushes the
// buffer and restarts fetching at the branch target.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   mem_req    out  read request, held until mem_ack (registered)
//   mem_addr   out  byte address of the request (registered)
//   mem_ack    in   one-cycle acknowledge, mem_rdata valid with it
//   mem_rdata  in   returned byte
//   br_ld      in   one-cycle redirect strobe
//   br_addr    in   redirect target
//   p_inc      in   decoder consumes the head byte
//   dc_en      out  head byte valid
//   data       out  head byte (holds last value while empty)
//   pc         out  address of the head byte
// Build option:
//   EJ32_FETCH_BYPASS_EN  when defined, an ack arriving while the FIFO is
//                         empty is forwarded to data/dc_en in the same cycle.
// ---------------------------------------------------------------------------
module ej32_fetch import ej32_pkg::*; #(
   parameter int unsigned AW       = 17,
   parameter int unsigned DEPTH    = FETCH_DEPTH_DEF,
   parameter int unsigned RST_ADDR = FETCH_RST_ADDR_DEF
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [7:0]    mem_rdata,
   input  logic          br_ld,
   input  logic [AW-1:0] br_addr,
   input  logic          p_inc,
   output logic          dc_en,
   output logic [7:0]    data,
   output logic [AW-1:0] pc
);

   localparam int unsigned   CW    = $clog2(DEPTH) + 1;
   localparam logic [AW-1:0] RST_A = AW'(RST_ADDR);

   fetch_st_t     st;
   fetch_st_t     st_nxt;
   logic [AW-1:0] fa;
   logic [AW-1:0] fa_nxt;
   logic [AW-1:0] pc_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [7:0]    head;
   logic [7:0]    data_hold;
   logic          fifo_empty;
   logic          ack_ok;
   logic          byp;
   logic          pop;
   logic          push;
   logic          fifo_pop;
   logic          room;

   ej32_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (br_ld),
      .push  (push),
      .pop   (fifo_pop),
      .wdata (mem_rdata),
      .head  (head),
      .count (count)
   );

   assign fifo_empty = (count == '0);

   // An ack is only useful in BUSY; a same-cycle redirect makes it stale.
   assign ack_ok = (st == BUSY) && mem_ack && !br_ld;

`ifdef EJ32_FETCH_BYPASS_EN
   assign byp = fifo_empty && ack_ok;
`else
   assign byp = 1'b0;
`endif

   assign dc_en    = !fifo_empty || byp;
   assign pop      = p_inc && dc_en && !br_ld;
   // A bypassed byte that the decoder takes right away never enters the FIFO.
   assign push     = ack_ok && !(byp && pop);
   assign fifo_pop = pop && !byp;

   always_comb begin
      data = data_hold;
      if (byp)              data = mem_rdata;
      else if (!fifo_empty) data = head;
   end

   always_comb begin
      count_nxt = count + CW'(push) - CW'(fifo_pop);
      if (br_ld) count_nxt = '0;
      // After this cycle no request is outstanding in the states that test
      // room, so a new one fits if the occupancy stays below DEPTH.
      room = (count_nxt < CW'(DEPTH));
   end

   always_comb begin
      st_nxt = st;
      fa_nxt = fa;
      pc_nxt = pc;

      if (br_ld)       fa_nxt = br_addr;
      else if (ack_ok) fa_nxt = fa + 1'b1;

      if (br_ld)    pc_nxt = br_addr;
      else if (pop) pc_nxt = pc + 1'b1;

      case (st)
         IDLE: begin
            if (br_ld || room) st_nxt = BUSY;
         end
         BUSY: begin
            if (br_ld)        st_nxt = mem_ack ? BUSY : FLUSH;
            else if (mem_ack) st_nxt = room ? BUSY : IDLE;
         end
         FLUSH: begin
            // The stale request must complete before the target is fetched;
            // a further redirect here only retargets fa.
            if (mem_ack) st_nxt = BUSY;
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st        <= IDLE;
         fa        <= RST_A;
         pc        <= RST_A;
         mem_req   <= 1'b0;
         mem_addr  <= RST_A;
         data_hold <= 8'h00;
      end else begin
         st        <= st_nxt;
         fa        <= fa_nxt;
         pc        <= pc_nxt;
         mem_req   <= (st_nxt != IDLE);
         // In FLUSH the old request is still on the bus; keep its address.
         if (st_nxt != FLUSH) mem_addr <= fa_nxt;
         data_hold <= data;
      end
   end

endmodule

// File: tb/tb_ej32_fetch.sv
// ---------------------------------------------------------------------------
// tb_ej32_fetch
// Directed bench for ej32_fetch with a behavioural instruction memory that
// answers each request after a programmable number of wait states.
// ---------------------------------------------------------------------------
module tb_ej32_fetch;
   import ej32_pkg::*;

   localparam int AW = 17;
`ifdef EJ32_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [7:0]    mem_rdata;
   logic          br_ld;
   logic [AW-1:0] br_addr;
   logic          p_inc;
   logic          dc_en;
   logic [7:0]    data;
   logic [AW-1:0] pc;

   int n_chk   = 0;
   int n_err   = 0;
   int ws      = 0;
   int wcnt    = 0;
   int ack_cnt = 0;
   bit resp_en = 1'b1;

   logic [7:0] seq [3] = '{8'h10, 8'h03, 8'h60};

   always #5 clk = ~clk;

   ej32_fetch #(
      .AW       (AW),
      .DEPTH    (4),
      .RST_ADDR (0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .br_ld     (br_ld),
      .br_addr   (br_addr),
      .p_inc     (p_inc),
      .dc_en     (dc_en),
      .data      (data),
      .pc        (pc)
   );

   function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
      case (a)
         17'h00000: mem_byte = 8'h10;
         17'h00001: mem_byte = 8'h03;
         17'h00002: mem_byte = 8'h60;
         17'h00100: mem_byte = 8'hA1;
         default:   mem_byte = a[7:0] ^ 8'hC3;
      endcase
   endfunction

   // Memory model: ack after ws idle cycles of a held request.
   always @(negedge clk) begin
      if (resp_en) begin
         if (mem_req) begin
            if (wcnt == ws) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_byte(mem_addr);
               wcnt      = 0;
               ack_cnt++;
            end else begin
               mem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst     = 1'b0;
      p_inc   = 1'b0;
      br_ld   = 1'b0;
      br_addr = '0;
      resp_en = 1'b1;
      ws      = 0;
      tick;
      tick;
      ack_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit            found;
      bit            first_new;
      bit            done;
      logic [AW-1:0] new_addr;

      rst = 1'b0; p_inc = 1'b0; br_ld = 1'b0; br_addr = '0;
      mem_ack = 1'b0; mem_rdata = 8'h00;
      repeat (3) tick;

      // Reset state
      check("rst_req",   32'(mem_req),  32'd0);
      check("rst_addr",  32'(mem_addr), 32'd0);
      check("rst_dcen",  32'(dc_en),    32'd0);
      check("rst_data",  32'(data),     32'd0);
      check("rst_pc",    32'(pc),       32'd0);
      check("rst_state", 32'(dut.st),   32'(IDLE));

      // T1: zero-wait stream 0x10,0x03,0x60 with p_inc held
      do_reset;
      p_inc = 1'b1;
      rst   = 1'b1;
      tick;
      check("t1_req",  32'(mem_req),  32'd1);
      check("t1_addr", 32'(mem_addr), 32'd0);
      check("t1_dc0",  32'(dc_en),    32'(BYP));
      for (int k = 0; k < 3; k++) begin
         if (k > 0 || !BYP) tick;
         check("t1_dcen", 32'(dc_en), 32'd1);
         check("t1_data", 32'(data),  32'(seq[k]));
         check("t1_pc",   32'(pc),    32'(k));
         if (BYP) check("t1_cnt", 32'(dut.u_fifo.count), 32'd0);
      end

      // T2: no consumption fills DEPTH bytes then idles; one pop refetches
      do_reset;
      rst = 1'b1;
      repeat (5) tick;
      check("t2_acks",  32'(ack_cnt),          32'd4);
      check("t2_req",   32'(mem_req),          32'd0);
      check("t2_state", 32'(dut.st),           32'(IDLE));
      check("t2_cnt",   32'(dut.u_fifo.count), 32'd4);
      check("t2_data",  32'(data),             32'h10);
      repeat (2) tick;
      check("t2_acks2", 32'(ack_cnt),          32'd4);
      p_inc = 1'b1;
      tick;
      p_inc = 1'b0;
      #1;
      check("t2_req2",  32'(mem_req),  32'd1);
      check("t2_addr2", 32'(mem_addr), 32'd4);
      check("t2_pc2",   32'(pc),       32'd1);
      check("t2_data2", 32'(data),     32'h03);

      // T3: 3 wait states, redirect while request to 0x5 is pending
      do_reset;
      ws    = 3;
      p_inc = 1'b1;
      rst   = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick;
         if (mem_req && mem_addr == 17'h5) found = 1'b1;
      end
      check("t3_reach", 32'(found), 32'd1);
      br_ld   = 1'b1;
      br_addr = 17'h100;
      tick;
      br_ld = 1'b0;
      #1;
      check("t3_hold_addr", 32'(mem_addr), 32'h5);
      check("t3_pc",        32'(pc),       32'h100);
      check("t3_dcen",      32'(dc_en),    32'd0);
      check("t3_state",     32'(dut.st),   32'(FLUSH));
      first_new = 1'b0;
      done      = 1'b0;
      new_addr  = '0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick;
         if (!first_new && mem_addr != 17'h5) begin
            first_new = 1'b1;
            new_addr  = mem_addr;
         end
         if (dc_en) done = 1'b1;
      end
      check("t3_done",     32'(done),     32'd1);
      check("t3_new_addr", 32'(new_addr), 32'h100);
      check("t3_data",     32'(data),     32'hA1);
      check("t3_pc_tgt",   32'(pc),       32'h100);

      // T4: redirect in the same cycle as an ack and a pop
      do_reset;
      p_inc = 1'b1;
      rst   = 1'b1;
      tick;
      tick;
      check("t4_pre_dcen", 32'(dc_en), 32'd1);
      br_ld   = 1'b1;
      br_addr = 17'h40;
      tick;
      br_ld = 1'b0;
      p_inc = 1'b0;
      #1;
      check("t4_cnt",  32'(dut.u_fifo.count), 32'd0);
      check("t4_pc",   32'(pc),               32'h40);
      check("t4_addr", 32'(mem_addr),         32'h40);
      check("t4_dcen", 32'(dc_en),            32'(BYP));
      if (BYP) check("t4_byp_data", 32'(data), 32'h83);
      tick;
      check("t4_dcen2", 32'(dc_en), 32'd1);
      check("t4_data2", 32'(data),  32'h83);
      check("t4_pc2",   32'(pc),    32'h40);

      // T5: address wrap at 2^AW-1
      do_reset;
      rst = 1'b1;
      tick;
      br_ld   = 1'b1;
      br_addr = 17'h1FFFF;
      tick;
      br_ld = 1'b0;
      #1;
      check("t5_addr_top", 32'(mem_addr), 32'h1FFFF);
      check("t5_pc_top",   32'(pc),       32'h1FFFF);
      tick;
      check("t5_addr_wrap", 32'(mem_addr), 32'd0);
      check("t5_dcen",      32'(dc_en),    32'd1);
      check("t5_data",      32'(data),     32'h3C);
      check("t5_pc",        32'(pc),       32'h1FFFF);
      p_inc = 1'b1;
      tick;
      p_inc = 1'b0;
      #1;
      check("t5_pc_wrap", 32'(pc),   32'd0);
      check("t5_data2",   32'(data), 32'h10);

      // T6: reset during a pending request; late ack ignored
      do_reset;
      resp_en = 1'b0;
      mem_ack = 1'b0;
      rst     = 1'b1;
      tick;
      check("t6_req", 32'(mem_req), 32'd1);
      rst       = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 8'h77;
      for (int i = 0; i < 2; i++) begin
         tick;
         check("t6_rst_req",  32'(mem_req),          32'd0);
         check("t6_rst_dcen", 32'(dc_en),            32'd0);
         check("t6_rst_cnt",  32'(dut.u_fifo.count), 32'd0);
      end
      rst     = 1'b1;
      mem_ack = 1'b0;
      tick;
      check("t6_req2",  32'(mem_req),  32'd1);
      check("t6_addr2", 32'(mem_addr), 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 8'h55;
      tick;
      mem_ack = 1'b0;
      #1;
      check("t6_dcen", 32'(dc_en), 32'd1);
      check("t6_data", 32'(data),  32'h55);
      resp_en = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ej32_fetch.md
# ej32_fetch

Instruction fetch and prefetch stage for eJ32, directly upstream of the decoder unit. Issues byte reads to the instruction memory port through a req/ack handshake and buffers bytes in a small FIFO. Presents the head byte and a valid flag to the decoder, and pops one byte whenever the decoder asserts `p_inc`. Flushes and refetches on a branch-target load from BR.

## Interface
Parameters:
- `AW`, 17: byte address width.
- `DEPTH`, 4: prefetch FIFO depth in bytes; power of two, minimum 2.
- `RST_ADDR`, 0: fetch address after reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `mem_req`  out  1  read request; held until acknowledged.
- `mem_addr`  out  AW  byte address; stable while `mem_req`=1.
- `mem_ack`  in  1  one-cycle acknowledge; `mem_rdata` is valid in this cycle.
- `mem_rdata`  in  8  returned byte.
- `br_ld`  in  1  one-cycle redirect strobe from BR.
- `br_addr`  in  AW  redirect target.
- `p_inc`  in  1  decoder consumes the head byte.
- `dc_en`  out  1  head byte is valid; drives the decoder enable.
- `data`  out  8  head byte; wired to the decoder `data` input.
- `pc`  out  AW  address of the head byte.

## Operation
- Fetch address `fa` advances by 1 on each accepted ack. `pc` advances by 1 on each pop.
- Only one request is outstanding at a time. A new request is issued only if `count + inflight < DEPTH`.
- FSM states:
  - IDLE: no request. Goes to BUSY when there is room.
  - BUSY: `mem_req`=1 at `fa`. On ack, the byte is pushed; the FSM stays in BUSY if there is room after the push, otherwise goes to IDLE.
  - FLUSH: a request is still outstanding but its data is stale. On ack, the data is discarded and the FSM goes to BUSY at the new `fa`.
- Pop occurs when `p_inc`=1 and `dc_en`=1. `p_inc` with `dc_en`=0 is ignored.
- Push and pop in the same cycle leave `count` unchanged.
- Redirect (`br_ld`=1):
  - FIFO is cleared, and `pc` and `fa` are loaded with `br_addr`.
  - From BUSY without an ack that cycle, the FSM goes to FLUSH.
  - From BUSY with an ack that cycle, the byte is discarded and the FSM goes to BUSY at `br_addr`.
  - From IDLE, the FSM goes to BUSY at `br_addr`.
  - `br_ld` has priority over a same-cycle push and pop.
  - `br_ld` during FLUSH reloads `fa` and stays in FLUSH.
- `data` shows the FIFO head whenever `dc_en`=1. It holds its last value when the FIFO is empty (no bypass).
- Address arithmetic wraps modulo 2^AW, so 2^AW−1 is followed by 0.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=RST_ADDR, `dc_en`=0, `data`=0, `pc`=RST_ADDR, FIFO empty, state IDLE.
- The first cycle after `rst` rises: `mem_req`=1, `mem_addr`=RST_ADDR.
- `mem_req` and `mem_addr` are registered outputs.
- Ack may arrive in the first cycle `mem_req` is high (zero-wait). With zero-wait memory, throughput is 1 byte per cycle.
- Latency from ack to `dc_en`=1 is 1 cycle (FIFO write, then read).
- After `br_ld`, `mem_addr`=`br_addr` on the next cycle, unless the FSM is in FLUSH. `dc_en`=0 from the cycle after `br_ld` until the first target byte lands.
- Reset asserted mid-request: all state returns to reset values, and a late ack is ignored while `rst`=0. An ack arriving in the first post-reset cycle is accepted as the response to the new request.

## Configuration
- `EJ32_FETCH_BYPASS_EN` defined:
  - When the FIFO is empty, the FSM is in BUSY, and `mem_ack`=1, then `data`=`mem_rdata` and `dc_en`=1 combinationally in the same cycle.
  - If `p_inc`=1 in that cycle, the byte is consumed and not written to the FIFO.
  - Ack-to-decode latency becomes 0.
- Not defined: there is no combinational path from `mem_rdata` or `mem_ack` to `data` or `dc_en`, and latency is 1.

## Structure
- Belongs in `ej32_pkg`:
  - `fetch_st_t` enum: IDLE, BUSY, FLUSH.
  - Default constants for `DEPTH` and `RST_ADDR`.
- Sub-module `ej32_fifo`:
  - Parametric byte FIFO with push, pop, synchronous clear, `count`, and `head`.
  - Pointer width is log2(DEPTH), with a separate count of log2(DEPTH)+1 bits.
- FSM, address counters and the bypass mux stay in `ej32_fetch`.

## Test plan
- Reset release with zero-wait memory returning 0x10,0x03,0x60 from address 0 and `p_inc` held at 1 → `dc_en` high from cycle 2, `data` sequence 0x10,0x03,0x60, `pc` 0,1,2.
- `p_inc`=0 with DEPTH=4 → exactly 4 acks, then `mem_req`=0 and the FSM in IDLE. One pop → `mem_req`=1 at address 4 the next cycle.
- Memory with 3 wait states and `br_ld` to 0x100 while the request to 0x5 is pending → the ack for 0x5 is discarded and the next `mem_addr`=0x100. `data` shows the byte at 0x100 first, with `pc`=0x100.
- `br_ld` in the same cycle as an ack and a pop → FIFO empty and `pc`=`br_addr`, with no byte from the old stream ever presented.
- `fa`=2^AW−1 → the next request goes to address 0, and `pc` wraps to 0.
- `EJ32_FETCH_BYPASS_EN` defined, FIFO empty, zero-wait memory → `dc_en`=1 in the ack cycle. With `p_inc`=1 the FIFO `count` stays 0.
